// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder
//
// Streams the (activation, weight) operand pairs of one neuron to a layer node's
// serial multiply-accumulate input, followed by a final (bias, 1) pair flagged
// s_last. Activations and weights are read from two synchronous single-port
// memories (one-cycle read latency) through a shared address.
//
// Optional feature macro: FEEDER_ZERO_SKIP_EN
//   defined   - pairs whose activation is zero are dropped before the output FIFO
//   undefined - every pair is streamed (N_INPUTS + 1 beats per start)
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   start, bias        one-cycle request to stream a neuron, with its bias
//   rd_en, rd_addr     read strobe and shared address to both memories
//   in_rdata, w_rdata  memory read data, valid the cycle after rd_en
//   s_valid, s_ready   output stream handshake
//   x_data, w_data     output pair (bias, 1 on the last beat)
//   s_last             marks the bias beat
//   busy, done         busy from start acceptance until done; done is a pulse

module mac_stream_feeder #(
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] w_rdata,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] x_data,
    output logic [DATA_W-1:0] w_data,
    output logic              s_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRun, StBias, StFlush} state_t;

    state_t              state_q, state_d;
    logic                start_ok;
    logic [DATA_W-1:0]   bias_q;
    logic [ADDR_W:0]     addr_q;       // next address to read; reaches N_INPUTS
    logic [ADDR_W-1:0]   rd_addr_q;    // last issued address
    logic                rd_pend_q;    // a read issued last cycle returns now
    logic                done_q;

    // 2-entry FIFO: head drives the outputs directly, tail is the spare slot
    logic [1:0]          cnt_q;
    logic [DATA_W-1:0]   head_x_q, head_w_q, tail_x_q, tail_w_q;
    logic                head_last_q, tail_last_q;

    logic                pop, push, push_rd, push_bias, keep_pair;
    logic                reads_left, bias_room;
    logic [2:0]          level;
    logic [DATA_W-1:0]   push_x, push_w;
    logic                push_last;

    assign pop        = (cnt_q != 2'd0) && s_ready;
    assign reads_left = addr_q < (ADDR_W+1)'(N_INPUTS);

    // Occupancy after this cycle's pop, counting the read that returns now.
    // pop implies cnt_q >= 1, so this never underflows.
    assign level = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};

    assign rd_en   = (state_q == StRun) && reads_left && (level < 3'd2);
    assign rd_addr = rd_en ? addr_q[ADDR_W-1:0] : rd_addr_q;

`ifdef FEEDER_ZERO_SKIP_EN
    assign keep_pair = (in_rdata != '0);
`else
    assign keep_pair = 1'b1;
`endif

    // Returned read data is taken unconditionally; the credit rule ensures room
    assign push_rd   = rd_pend_q && keep_pair;
    assign bias_room = (cnt_q != 2'd2) || pop;
    assign push_bias = (state_q == StBias) && bias_room;
    assign push      = push_rd || push_bias;
    assign push_x    = push_bias ? bias_q : in_rdata;
    assign push_w    = push_bias ? DATA_W'(1) : w_rdata;
    assign push_last = push_bias;

    assign s_valid = (cnt_q != 2'd0);
    assign x_data  = head_x_q;
    assign w_data  = head_w_q;
    assign s_last  = head_last_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        unique case (state_q)
            StIdle: begin
                // a start coincident with the done pulse is ignored
                if (start && !done_q) begin
                    state_d  = StRun;
                    start_ok = 1'b1;
                end
            end
            StRun: begin
                // all reads issued and the final one is returning this cycle
                if (!reads_left && rd_pend_q) state_d = StBias;
            end
            StBias: begin
                if (push_bias) state_d = StFlush;
            end
            StFlush: begin
                if (pop && head_last_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bias_q      <= '0;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 2'd0;
            head_x_q    <= '0;
            head_w_q    <= '0;
            head_last_q <= 1'b0;
            tail_x_q    <= '0;
            tail_w_q    <= '0;
            tail_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_en;
            done_q    <= (state_q == StFlush) && pop && head_last_q;

            if (start_ok) begin
                bias_q <= bias;
                addr_q <= '0;
            end else if (rd_en) begin
                addr_q <= addr_q + 1'b1;
            end

            if (rd_en) rd_addr_q <= addr_q[ADDR_W-1:0];

            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_x_q    <= push_x;
                        head_w_q    <= push_w;
                        head_last_q <= push_last;
                    end else begin
                        tail_x_q    <= push_x;
                        tail_w_q    <= push_w;
                        tail_last_q <= push_last;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_x_q    <= tail_x_q;
                    head_w_q    <= tail_w_q;
                    head_last_q <= tail_last_q;
                    cnt_q       <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_x_q    <= push_x;
                        head_w_q    <= push_w;
                        head_last_q <= push_last;
                    end else begin
                        head_x_q    <= tail_x_q;
                        head_w_q    <= tail_w_q;
                        head_last_q <= tail_last_q;
                        tail_x_q    <= push_x;
                        tail_w_q    <= push_w;
                        tail_last_q <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Self-checking bench for mac_stream_feeder: memory models, a beat-list reference
// built from the streaming rules, directed runs with randomized data and ready.
module tb_mac_stream_feeder;

    localparam int N = 784;

    logic        clk = 1'b0;
    logic        rst, start, rd_en, s_valid, s_ready, s_last, busy, done;
    logic [31:0] bias, in_rdata, w_rdata, x_data, w_data;
    logic [9:0]  rd_addr;

    logic [31:0] in_mem [1024];
    logic [31:0] w_mem  [1024];

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] w;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    mac_stream_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bias     (bias),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .in_rdata (in_rdata),
        .w_rdata  (w_rdata),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .x_data   (x_data),
        .w_data   (w_data),
        .s_last   (s_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            in_rdata <= in_mem[rd_addr];
            w_rdata  <= w_mem[rd_addr];
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every pair in address order (nonzero activations only when
    // zero skipping is built in), then the bias pair.
    task automatic build_expected(input logic [31:0] b);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
`ifdef FEEDER_ZERO_SKIP_EN
            if (in_mem[i] != 32'd0)
`endif
                exp_q.push_back({in_mem[i], w_mem[i], 1'b0});
        end
        exp_q.push_back({b, 32'd1, 1'b1});
    endtask

    // mode 0: s_ready always high, 1: random. inject_at/abort_at < 0 disables.
    task automatic run_stream(input logic [31:0] b, input int mode, input int inject_at,
                              input int abort_at, input bit timing);
        int          cyc, beats, issued, data_acc;
        bit          finished, prev_stall, injected;
        logic [64:0] prev;
        finished = 0; prev_stall = 0; injected = 0;
        beats = 0; issued = 0; data_acc = 0; prev = '0;
        build_expected(b);
        @(negedge clk);
        start = 1'b1;
        bias  = b;
        @(negedge clk);           // start accepted at the edge just passed: now cycle 1
        start = 1'b0;
        bias  = $urandom;         // must not be resampled
        cyc   = 1;
        while (!finished && cyc < 20000) begin
            s_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start   = 1'b0;
            if (inject_at >= 0 && beats == inject_at && !injected) begin
                start    = 1'b1;
                bias     = 32'h1234_5678;
                injected = 1;
            end
            #1;
            if (cyc == 1) begin
                check("first_rd_en", 96'(rd_en), 96'd1);
                check("first_rd_addr", 96'(rd_addr), 96'd0);
            end
            if (prev_stall) begin
                check("stall_valid", 96'(s_valid), 96'd1);
                check("stall_data", 96'({x_data, w_data, s_last}), 96'(prev));
            end
            if (rd_en) issued++;
            if (s_valid && s_ready) begin
                if (beats < exp_q.size())
                    check("beat", 96'({x_data, w_data, s_last}), 96'(exp_q[beats]));
                else
                    check("beat_overrun", 96'(beats), 96'(exp_q.size() - 1));
                if (timing && beats == 0) check("first_beat_cycle", 96'(cyc), 96'd3);
                if (timing && s_last) check("last_beat_cycle", 96'(cyc), 96'd787);
                if (!s_last) data_acc++;
                beats++;
            end
`ifndef FEEDER_ZERO_SKIP_EN
            check("outstanding_le2", 96'((issued - data_acc) <= 2), 96'd1);
`endif
            prev_stall = s_valid && !s_ready;
            prev       = {x_data, w_data, s_last};
            if (abort_at >= 0 && beats == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("abort_state", 96'({s_valid, s_last, busy, done, rd_en}), 96'd0);
                check("abort_data", 96'({rd_addr, x_data, w_data}), 96'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #1;
                    check("abort_no_done", 96'({done, s_valid}), 96'd0);
                end
                finished = 1;
            end else if (done) begin
                check("done_beats", 96'(beats), 96'(exp_q.size()));
                check("done_busy_low", 96'(busy), 96'd0);
                if (timing) check("done_cycle", 96'(cyc), 96'd788);
                finished = 1;
                start    = 1'b1;  // coincides with done: must be ignored
                @(negedge clk);
                start = 1'b0;
                #1;
                check("start_at_done_ignored", 96'(busy), 96'd0);
                @(negedge clk);
                #1;
                check("done_single_pulse", 96'(done), 96'd0);
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("stream_finished", 96'(finished), 96'd1);
    endtask

    task automatic fill_counting();
        for (int i = 0; i < 1024; i++) begin
            in_mem[i] = 32'(i + 1);
            w_mem[i]  = 32'd2;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bias = '0; s_ready = 1'b0;
        fill_counting();
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", 96'({s_valid, s_last, busy, done, rd_en}), 96'd0);
        check("reset_data", 96'({rd_addr, x_data, w_data}), 96'd0);
        rst = 1'b0;

        // Counting activations, ready held high, exact cycle timing
        run_stream(32'd5, 0, -1, -1, 1);

        // Random data with random backpressure
        for (int i = 0; i < 1024; i++) begin
            in_mem[i] = $urandom;
            w_mem[i]  = $urandom;
        end
        run_stream($urandom, 1, -1, -1, 0);

        // Start pulse mid-stream is ignored; original bias must still appear
        fill_counting();
        run_stream(32'd77, 1, 100, -1, 0);

        // Abort at beat 400, then a clean run with a negative bias
        run_stream(32'd9, 1, -1, 400, 0);
        run_stream(32'hFFFF_FFFD, 1, -1, -1, 0);

`ifdef FEEDER_ZERO_SKIP_EN
        for (int i = 0; i < 1024; i++) begin
            in_mem[i] = 32'd0;
            w_mem[i]  = $urandom;
        end
        in_mem[10]  = 32'hDEAD_0010;
        in_mem[500] = 32'h0000_0500;
        run_stream(32'd42, 1, -1, -1, 0);
        in_mem[10]  = 32'd0;
        in_mem[500] = 32'd0;
        run_stream(32'd43, 0, -1, -1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_stream_feeder.md
# mac_stream_feeder

Streams the operand pairs for one neuron's multiply-accumulate to a layer node in the digit-detection network. Reads the 784 input activations and matching weights from two synchronous single-port memories through one shared address. Emits them as a valid/ready stream of (x, w) pairs, then appends the bias as a final (bias, 1) pair flagged `s_last`. The block is the producer side of the node's serial input interface, and a node consumes one pair per accepted beat.

## Interface
- `N_INPUTS`, 784, number of (input, weight) pairs per neuron
- `DATA_W`, 32, width of activations, weights, bias (two's complement)
- `ADDR_W`, 10, memory address width; must satisfy 2^ADDR_W ≥ N_INPUTS

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to stream one neuron; ignored while `busy`
- `bias`  in  DATA_W  neuron bias; sampled in the cycle `start` is accepted
- `rd_en`  out  1  read strobe to both memories
- `rd_addr`  out  ADDR_W  shared read address (input buffer and weight ROM)
- `in_rdata`  in  DATA_W  input activation; valid the cycle after `rd_en`
- `w_rdata`  in  DATA_W  weight; valid the cycle after `rd_en`
- `s_valid`  out  1  pair available
- `s_ready`  in  1  node accepts pair
- `x_data`  out  DATA_W  activation, or bias on the last beat
- `w_data`  out  DATA_W  weight, or 32'h0000_0001 on the last beat
- `s_last`  out  1  marks the bias beat
- `busy`  out  1  high from start acceptance until `done`
- `done`  out  1  one-cycle pulse after the last beat handshakes

## Operation
- FSM states: IDLE, RUN, BIAS, FLUSH.
  - IDLE→RUN on `start`. Latch `bias`, clear the address counter, set `busy`.
  - RUN issues reads for addresses 0..N_INPUTS-1 in ascending order. RUN→BIAS when the data for address N_INPUTS-1 is written into the buffer.
  - BIAS writes the pair (bias, 1) with last=1 into the buffer in the first cycle it has room, then goes to FLUSH.
  - FLUSH→IDLE when the last beat handshakes. `done` pulses in the following cycle and `busy` drops with it.
- Output buffer: 2-entry FIFO, registered outputs. `x_data`/`w_data`/`s_last` come from the head entry.
- Read credit: assert `rd_en` in RUN only when (fifo_count + reads_in_flight − pop_this_cycle) < 2, where pop = `s_valid && s_ready`. This gives no overflow and one pair per cycle while `s_ready` stays high.
- Read data is captured unconditionally the cycle after `rd_en`. The credit rule guarantees there is room for it.
- Stream rules:
  - `s_valid` must not drop without a handshake.
  - `x_data`/`w_data`/`s_last` stay stable while `s_valid && !s_ready`.
  - `s_valid` never depends combinationally on `s_ready`.
- Beat order always matches address order. Exactly one `s_last` beat per `start`.
- `rd_addr` holds its last value when `rd_en` is low. The value is don't-care for memories.

## Timing
- Reset values:
  - `s_valid`, `s_last`, `busy`, `done`, `rd_en` = 0.
  - `rd_addr`, `x_data`, `w_data` = 0.
  - FIFO and in-flight counters are empty; FSM is in IDLE.
- Cycle numbering, with `start` accepted at cycle 0 and `s_ready` held high:
  - `rd_en`/addr 0 in cycle 1.
  - First beat valid in cycle 3.
  - Data beats in cycles 3..786, one per cycle.
  - Bias beat in cycle 787.
  - `done` in cycle 788.
- Backpressure: with `s_ready` low, at most two reads are outstanding or buffered combined. Streaming resumes at one beat per cycle the cycle `s_ready` returns.
- `start` while `busy` is ignored, and `bias` is not resampled. `start` in the same cycle as `done` is ignored; a new start is accepted from the next cycle.
- `rst` mid-stream:
  - Next cycle returns to IDLE and flushes the FIFO.
  - Read data from an in-flight read is discarded.
  - All outputs take their reset values.
  - No `done` pulse.

## Configuration
- `FEEDER_ZERO_SKIP_EN` defined: returned pairs whose `in_rdata` == 0 are dropped and never written to the FIFO. All N_INPUTS reads are still issued, and reads do not stall on a dropped pair. The bias beat is always emitted with `s_last`=1. Beat count = nonzero inputs + 1.
- Not defined: every pair is streamed, giving exactly N_INPUTS+1 beats.

## Test plan
- Reset, then `start` with bias=5, memories mem[i]=i+1, weights=2, `s_ready`=1:
  - Beats (1,2)..(784,2), then (5,1) with `s_last` in cycle 787.
  - `done` in cycle 788.
  - 785 beats total.
- Same stream with `s_ready` toggling at random (≈50%): identical beat sequence, stable data while stalled, FIFO never overflows, at most 2 reads outstanding plus buffered.
- Pulse `start` at beat 100 with a different bias: ignored, and the original bias is still emitted on the last beat.
- Assert `rst` at beat 400, release it, then start again with bias=−3 (32'hFFFF_FFFD): no `done` for the aborted run, and the new run streams 785 beats from address 0 and ends with (FFFF_FFFD, 1).
- With `FEEDER_ZERO_SKIP_EN` and only mem[10], mem[500] nonzero: exactly 3 beats, (mem[10],w10), (mem[500],w500), (bias,1) with last.
- With `FEEDER_ZERO_SKIP_EN` and all activations zero: a single beat (bias,1) with `s_last`=1, followed by `done`.
